// File: rtl/plot_readback_buffer_if.sv
// rtl/plot_readback_buffer_if.sv - plot, read and clear bus between game logic and plot_readback_buffer
//   plot/x/y/colour          : pixel write strobe and data (mirrors the VGA plot inputs)
//   rd_start/rd_x/rd_y       : single-pixel read request
//   rd_colour/rd_valid       : read result and its one-cycle update pulse
//   clr_start/clr_colour     : bulk clear request and fill colour
//   waitrequest              : responder busy; requests only accepted while low
//   master = game logic side, slave = buffer side
interface plot_readback_buffer_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       rd_start;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] rd_colour;
    logic       rd_valid;
    logic       clr_start;
    logic [2:0] clr_colour;
    logic       waitrequest;

    modport master (
        output plot, x, y, colour, rd_start, rd_x, rd_y, clr_start, clr_colour,
        input  rd_colour, rd_valid, waitrequest
    );

    modport slave (
        input  plot, x, y, colour, rd_start, rd_x, rd_y, clr_start, clr_colour,
        output rd_colour, rd_valid, waitrequest
    );
endinterface

// File: rtl/plot_readback_buffer.sv
// rtl/plot_readback_buffer.sv - pixel mirror of the VGA plot stream with read and bulk-clear responder
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (memory contents are not reset)
//   bus    : plot_readback_buffer_if.slave (plot writes, reads, clear, waitrequest)
//   Optional macro PLOT_READ_BYPASS_EN: forward a same-address plot issued in the
//   RD_ISSUE cycle to the read result instead of returning the old memory value.
module plot_readback_buffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    plot_readback_buffer_if.slave  bus
);
    localparam int                DEPTH   = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_oor_q;
    logic [2:0]        rd_colour_q;
    logic [2:0]        clr_colour_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [2:0]        ram_rdata_q;
    logic [2:0]        mem [DEPTH];

    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [2:0]        wdata;
    logic              clr_accept, rd_accept;
    logic [2:0]        rd_result;

    // Addresses are formed at full ADDR_W width so x/y never wrap before the range check.
    assign wr_ok   = (int'(bus.x) < WIDTH) && (int'(bus.y) < HEIGHT);
    assign rd_ok   = (int'(bus.rd_x) < WIDTH) && (int'(bus.rd_y) < HEIGHT);
    assign wr_addr = ADDR_W'(bus.y) * WIDTH_A + ADDR_W'(bus.x);
    assign rd_addr = ADDR_W'(bus.rd_y) * WIDTH_A + ADDR_W'(bus.rd_x);

    // Clear has priority; a read presented alongside it is dropped.
    assign clr_accept = (state_q == IDLE) && bus.clr_start;
    assign rd_accept  = (state_q == IDLE) && bus.rd_start && !bus.clr_start;

    // Single write port: the clear sweep owns it, otherwise in-range plots.
    always_comb begin
        we    = 1'b0;
        waddr = wr_addr;
        wdata = bus.colour;
        if (state_q == CLEAR) begin
            we    = 1'b1;
            waddr = clr_cnt_q;
            wdata = clr_colour_q;
        end else begin
            we = bus.plot && wr_ok;
        end
    end

    // RAM reads every cycle; the value captured at the end of RD_ISSUE is used in RD_DATA.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        ram_rdata_q <= mem[rd_addr_q];
    end

`ifdef PLOT_READ_BYPASS_EN
    logic       byp_hit_q;
    logic [2:0] byp_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= 3'd0;
        end else begin
            byp_hit_q  <= (state_q == RD_ISSUE) && bus.plot && wr_ok && !rd_oor_q
                          && (wr_addr == rd_addr_q);
            byp_data_q <= bus.colour;
        end
    end

    assign rd_result = rd_oor_q  ? 3'd0 :
                       byp_hit_q ? byp_data_q : ram_rdata_q;
`else
    assign rd_result = rd_oor_q ? 3'd0 : ram_rdata_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clr_accept) begin
                    state_d = CLEAR;
                end else if (rd_accept) begin
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA:  state_d = IDLE;
            CLEAR: begin
                if (clr_cnt_q == LAST_A) begin
                    state_d = IDLE;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.waitrequest = (state_q == RD_ISSUE) || (state_q == CLEAR);
        bus.rd_valid    = (state_q == RD_DATA);
        bus.rd_colour   = (state_q == RD_DATA) ? rd_result : rd_colour_q;
    end

    // Out-of-range reads park the RAM address at 0; the result is forced to 0 anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q    <= '0;
            rd_oor_q     <= 1'b0;
            rd_colour_q  <= 3'd0;
            clr_colour_q <= 3'd0;
            clr_cnt_q    <= '0;
        end else begin
            if (rd_accept) begin
                rd_addr_q <= rd_ok ? rd_addr : '0;
                rd_oor_q  <= !rd_ok;
            end
            if (state_q == RD_DATA) begin
                rd_colour_q <= rd_result;
            end
            if (clr_accept) begin
                clr_colour_q <= bus.clr_colour;
                clr_cnt_q    <= '0;
            end else if (state_q == CLEAR) begin
                clr_cnt_q <= (clr_cnt_q == LAST_A) ? '0 : clr_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_plot_readback_buffer.sv
// tb/tb_plot_readback_buffer.sv - directed self-checking bench for plot_readback_buffer
module tb_plot_readback_buffer;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    plot_readback_buffer_if bus ();

    plot_readback_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PLOT_READ_BYPASS_EN
    localparam logic [2:0] BYP_EXP = 3'b110;
`else
    localparam logic [2:0] BYP_EXP = 3'b001;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        bus.plot   = 1'b1;
        bus.x      = px[7:0];
        bus.y      = py[6:0];
        bus.colour = c;
        tick();
        bus.plot   = 1'b0;
    endtask

    // Issues a read at the current negedge (buffer must be idle) and checks the 2-cycle response.
    task automatic do_read(input int px, input int py, input logic [2:0] exp, input string tag);
        bus.rd_start = 1'b1;
        bus.rd_x     = px[7:0];
        bus.rd_y     = py[6:0];
        tick();
        bus.rd_start = 1'b0;
        check({tag, "_wait_issue"}, bus.waitrequest, 1);
        check({tag, "_valid_issue"}, bus.rd_valid, 0);
        tick();
        check({tag, "_valid"}, bus.rd_valid, 1);
        check({tag, "_colour"}, bus.rd_colour, exp);
        check({tag, "_wait_data"}, bus.waitrequest, 0);
        tick();
        check({tag, "_valid_drop"}, bus.rd_valid, 0);
    endtask

    // Counts busy cycles of a clear already accepted; optionally plots during it.
    task automatic run_clear(output int busy, output int pulses, input bit plot_during);
        busy   = 0;
        pulses = 0;
        while (bus.waitrequest === 1'b1 && busy < 25000) begin
            if (bus.rd_valid === 1'b1) pulses++;
            if (plot_during && busy == 10) begin
                bus.plot = 1'b1; bus.x = 8'd5; bus.y = 7'd5; bus.colour = 3'b111;
            end else begin
                bus.plot = 1'b0;
            end
            tick();
            busy++;
        end
        bus.plot = 1'b0;
    endtask

    initial begin
        int   busy, pulses;
        logic [5:0] vpat;

        rst_n          = 1'b0;
        bus.plot       = 1'b0;
        bus.x          = '0;
        bus.y          = '0;
        bus.colour     = '0;
        bus.rd_start   = 1'b0;
        bus.rd_x       = '0;
        bus.rd_y       = '0;
        bus.clr_start  = 1'b0;
        bus.clr_colour = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_wait", bus.waitrequest, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_colour", bus.rd_colour, 0);

        // Plot then read back with the specified latency
        plot_px(10, 5, 3'b100);
        do_read(10, 5, 3'b100, "t1");

        // Full clear to 010 with a plot during it that must not survive
        bus.clr_start  = 1'b1;
        bus.clr_colour = 3'b010;
        tick();
        bus.clr_start  = 1'b0;
        run_clear(busy, pulses, 1'b1);
        check("clr_busy_cycles", busy, 19200);
        check("clr_wait_after", bus.waitrequest, 0);
        do_read(0, 0, 3'b010, "clr_00");
        do_read(159, 119, 3'b010, "clr_last");
        do_read(80, 60, 3'b010, "clr_mid");
        do_read(5, 5, 3'b010, "clr_plot_dropped");

        // Clear and read together: clear wins, read is dropped
        bus.clr_start  = 1'b1;
        bus.clr_colour = 3'b000;
        bus.rd_start   = 1'b1;
        bus.rd_x       = 8'd10;
        bus.rd_y       = 7'd5;
        tick();
        bus.clr_start  = 1'b0;
        bus.rd_start   = 1'b0;
        check("simul_wait", bus.waitrequest, 1);
        run_clear(busy, pulses, 1'b0);
        check("simul_busy_cycles", busy, 19200);
        check("simul_no_valid", pulses, 0);
        tick();
        check("simul_no_valid_after", bus.rd_valid, 0);

        // Out-of-range writes dropped (no aliasing), out-of-range read returns 0
        plot_px(40, 11, 3'b101);
        plot_px(160, 0, 3'b111);
        plot_px(0, 120, 3'b111);
        do_read(0, 0, 3'b000, "oor_w00");
        do_read(0, 1, 3'b000, "oor_w01");
        do_read(200, 10, 3'b000, "oor_read");
        do_read(40, 11, 3'b101, "alias_target");

        // Same-address plot during RD_ISSUE
        plot_px(3, 3, 3'b001);
        bus.rd_start = 1'b1;
        bus.rd_x     = 8'd3;
        bus.rd_y     = 7'd3;
        tick();
        bus.rd_start = 1'b0;
        bus.plot     = 1'b1;
        bus.x        = 8'd3;
        bus.y        = 7'd3;
        bus.colour   = 3'b110;
        check("byp_wait_issue", bus.waitrequest, 1);
        tick();
        bus.plot = 1'b0;
        check("byp_valid", bus.rd_valid, 1);
        check("byp_colour", bus.rd_colour, BYP_EXP);
        tick();
        do_read(3, 3, 3'b110, "byp_after");

        // Back-to-back reads with rd_start held: one read per 3 cycles
        bus.rd_start = 1'b1;
        bus.rd_x     = 8'd40;
        bus.rd_y     = 7'd11;
        vpat = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            vpat[k] = bus.rd_valid;
        end
        bus.rd_start = 1'b0;
        check("b2b_valid_pattern", vpat, 6'b010010);
        check("b2b_colour", bus.rd_colour, 3'b101);
        tick();
        tick();

        // Reset 100 cycles into a clear
        bus.clr_start  = 1'b1;
        bus.clr_colour = 3'b101;
        tick();
        bus.clr_start  = 1'b0;
        repeat (99) tick();
        check("mid_clr_busy", bus.waitrequest, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_wait", bus.waitrequest, 0);
        check("rstmid_valid", bus.rd_valid, 0);
        check("rstmid_colour", bus.rd_colour, 0);
        tick();
        rst_n = 1'b1;
        do_read(3, 3, 3'b110, "post_rst_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
